// File: rtl/ooop_types_pkg.sv
// Shared out-of-order pipeline types: renamed/issue packets, RS entry layout,
// and the lowest-index priority decoder used for free-slot selection.
package ooop_types;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned PREG_W    = 6;
    localparam int unsigned ROB_TAG_W = 5;

    // Priority decoder capacity; stations deeper than this need a wider decoder.
    localparam int unsigned PD_MAX_W  = 64;
    localparam int unsigned PD_IDX_W  = 6;

    typedef struct packed {
        logic [7:0]        opcode;
        logic [PREG_W-1:0] rd_tag;
        logic [PREG_W-1:0] rs1_tag;
        logic              rs1_ready;
        logic [PREG_W-1:0] rs2_tag;
        logic              rs2_ready;
        logic [XLEN-1:0]   imm;
    } rename_pkt_t;

    typedef struct packed {
        logic [ROB_TAG_W-1:0] rob_tag;
        rename_pkt_t          pkt;
    } issue_pkt_t;

    typedef struct packed {
        logic [ROB_TAG_W-1:0] rob_tag;
        rename_pkt_t          pkt;
    } rs_entry_t;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [PD_IDX_W-1:0] priority_decoder(input logic [PD_MAX_W-1:0] req);
        logic [PD_IDX_W-1:0] idx;
        logic                found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < PD_MAX_W; i++) begin
            if (req[i] && !found) begin
                idx   = PD_IDX_W'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/reservation_station_age_age_matrix.sv
// Age matrix: older_q[i][j]=1 means entry i was allocated before entry j.
// Grants the single requesting entry that no other requesting entry is older than.
module rs_age_matrix #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc_valid_i,
    input  logic [$clog2(DEPTH)-1:0] alloc_idx_i,
    input  logic [DEPTH-1:0]         valid_i,
    input  logic [DEPTH-1:0]         req_i,
    output logic [DEPTH-1:0]         grant_o,
    output logic                     grant_valid_o
);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0] older_q [DEPTH];
    logic [DEPTH-1:0] older_d [DEPTH];
    logic [DEPTH-1:0] blocked;

    // New allocation is younger than every currently valid entry.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            older_d[i] = older_q[i];
        end
        if (alloc_valid_i) begin
            older_d[alloc_idx_i] = '0;
            for (int unsigned j = 0; j < DEPTH; j++) begin
                if (valid_i[j] && (IDX_W'(j) != alloc_idx_i)) begin
                    older_d[j][alloc_idx_i] = 1'b1;
                end
            end
        end
    end

    // Matrix state; stale rows of freed slots are masked by the valid bits.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (rst) older_q[i] <= '0;
            else     older_q[i] <= older_d[i];
        end
    end

    // A requester is blocked if any other requester is older.
    always_comb begin
        blocked = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            for (int unsigned j = 0; j < DEPTH; j++) begin
                if ((j != i) && req_i[j] && older_q[j][i]) blocked[i] = 1'b1;
            end
        end
        grant_o       = req_i & ~blocked;
        grant_valid_o = |grant_o;
    end

endmodule

// File: rtl/reservation_station_age.sv
// Reservation station with age-matrix oldest-first issue and NUM_WAKEUP CDB
// wakeup ports. Optional macro RS_WAKEUP_BYPASS_EN lets a same-cycle wakeup of
// an entry's last missing operand make it issuable in that cycle.
module reservation_station_age
    import ooop_types::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned NUM_WAKEUP = 2,
    parameter int unsigned AF_MARGIN  = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush_i,
    input  logic                           push_valid_i,
    output logic                           push_ready_o,
    input  rename_pkt_t                    push_pkt_i,
    input  logic [ROB_TAG_W-1:0]           push_rob_tag_i,
    input  logic [NUM_WAKEUP-1:0]          wakeup_valid_i,
    input  logic [NUM_WAKEUP*PREG_W-1:0]   wakeup_tag_i,
    input  logic                           exec_ready_i,
    output logic                           issue_valid_o,
    output issue_pkt_t                     issue_pkt_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o,
    output logic                           almost_full_o
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0] valid_q, valid_d;
    rs_entry_t        entry_q [DEPTH];
    rs_entry_t        entry_d [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;

    logic [DEPTH-1:0] free_vec, ready_vec, grant;
    logic [DEPTH-1:0] rs1_wake, rs2_wake;
    logic [IDX_W-1:0] free_idx;
    logic             grant_valid, push_fire, issue_fire;
    logic             push_rs1_hit, push_rs2_hit;
    rs_entry_t        sel_entry;

    function automatic logic tag_hit(input logic [PREG_W-1:0] tag);
        logic hit;
        hit = 1'b0;
        for (int unsigned p = 0; p < NUM_WAKEUP; p++) begin
            if (wakeup_valid_i[p] && (wakeup_tag_i[p*PREG_W +: PREG_W] == tag)) hit = 1'b1;
        end
        return hit;
    endfunction

    assign free_vec     = ~valid_q;
    assign free_idx     = IDX_W'(priority_decoder(PD_MAX_W'(free_vec)));
    assign push_ready_o = !rst && (|free_vec);
    assign push_fire    = push_valid_i && push_ready_o && !flush_i;
    assign issue_valid_o = grant_valid && !rst && !flush_i;
    assign issue_fire   = issue_valid_o && exec_ready_i;
    assign count_o      = count_q;
    assign almost_full_o = !rst && (count_q >= CNT_W'(DEPTH - AF_MARGIN));
    assign push_rs1_hit = tag_hit(push_pkt_i.rs1_tag);
    assign push_rs2_hit = tag_hit(push_pkt_i.rs2_tag);

    // Per-entry wakeup matches and the issue request vector.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            rs1_wake[i] = tag_hit(entry_q[i].pkt.rs1_tag);
            rs2_wake[i] = tag_hit(entry_q[i].pkt.rs2_tag);
`ifdef RS_WAKEUP_BYPASS_EN
            ready_vec[i] = valid_q[i] && (entry_q[i].pkt.rs1_ready || rs1_wake[i])
                                      && (entry_q[i].pkt.rs2_ready || rs2_wake[i]);
`else
            ready_vec[i] = valid_q[i] && entry_q[i].pkt.rs1_ready && entry_q[i].pkt.rs2_ready;
`endif
        end
    end

    rs_age_matrix #(.DEPTH(DEPTH)) u_age (
        .clk           (clk),
        .rst           (rst),
        .alloc_valid_i (push_fire),
        .alloc_idx_i   (free_idx),
        .valid_i       (valid_q),
        .req_i         (ready_vec),
        .grant_o       (grant),
        .grant_valid_o (grant_valid)
    );

    // One-hot grant mux onto the issue packet; zero when nothing issues.
    always_comb begin
        sel_entry = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (grant[i]) sel_entry = entry_q[i];
        end
        issue_pkt_o = '0;
        if (issue_valid_o) begin
            issue_pkt_o.rob_tag = sel_entry.rob_tag;
            issue_pkt_o.pkt     = sel_entry.pkt;
`ifdef RS_WAKEUP_BYPASS_EN
            issue_pkt_o.pkt.rs1_ready = 1'b1;
            issue_pkt_o.pkt.rs2_ready = 1'b1;
`endif
        end
    end

    // Next state: wakeups, issue release, push allocation with capture, flush.
    always_comb begin
        valid_d = valid_q;
        count_d = count_q + CNT_W'(push_fire) - CNT_W'(issue_fire);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            entry_d[i] = entry_q[i];
            if (valid_q[i]) begin
                entry_d[i].pkt.rs1_ready = entry_q[i].pkt.rs1_ready | rs1_wake[i];
                entry_d[i].pkt.rs2_ready = entry_q[i].pkt.rs2_ready | rs2_wake[i];
            end
            if (issue_fire && grant[i]) valid_d[i] = 1'b0;
        end
        if (push_fire) begin
            valid_d[free_idx]               = 1'b1;
            entry_d[free_idx].rob_tag       = push_rob_tag_i;
            entry_d[free_idx].pkt           = push_pkt_i;
            entry_d[free_idx].pkt.rs1_ready = push_pkt_i.rs1_ready | push_rs1_hit;
            entry_d[free_idx].pkt.rs2_ready = push_pkt_i.rs2_ready | push_rs2_hit;
        end
        if (flush_i) begin
            valid_d = '0;
            count_d = '0;
        end
    end

    // Registered station state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) entry_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            for (int unsigned i = 0; i < DEPTH; i++) entry_q[i] <= entry_d[i];
        end
    end

endmodule
